// File: rtl/mips32_sim_pkg.sv
// mips32_sim_pkg: run-monitor FSM states and done-cause codes
package mips32_sim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} run_state_t;
  localparam logic [1:0] DONE_NONE    = 2'b00;
  localparam logic [1:0] DONE_HALT    = 2'b01;
  localparam logic [1:0] DONE_TIMEOUT = 2'b10;
endpackage

// File: rtl/mips32_trace_buf.sv
// mips32_trace_buf: circular store trace with saturating count, sticky overflow and registered oldest-relative read
module mips32_trace_buf #(
  parameter int TRACE_DEPTH = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              wa,
  input  logic [DATA_W-1:0]              wd,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]              rd_addr,
  output logic [DATA_W-1:0]              rd_data,
  output logic [$clog2(TRACE_DEPTH):0]   count,
  output logic                           overflow
);
  localparam int IW = $clog2(TRACE_DEPTH);
  logic [ADDR_W+DATA_W-1:0] mem [TRACE_DEPTH];
  logic [IW-1:0] wr_ptr_q, wr_ptr_d, oldest, slot;
  logic [IW:0] count_q, count_d;
  logic overflow_q, overflow_d, full, hit;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  // oldest entry sits count slots behind the write pointer; a full buffer wraps it onto the pointer itself
  always_comb begin
    full       = count_q == (IW+1)'(TRACE_DEPTH);
    oldest     = wr_ptr_q - count_q[IW-1:0];
    slot       = oldest + rd_idx;
    hit        = {1'b0, rd_idx} < count_q;
    wr_ptr_d   = clr ? '0 : we ? wr_ptr_q + IW'(1) : wr_ptr_q;
    count_d    = clr ? '0 : (we && !full) ? count_q + (IW+1)'(1) : count_q;
    overflow_d = clr ? 1'b0 : overflow_q | (we & full);
    rd_addr_d  = hit ? mem[slot][ADDR_W+DATA_W-1:DATA_W] : '0;
    rd_data_d  = hit ? mem[slot][DATA_W-1:0] : '0;
  end
  // pointer, count, overflow and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end
  // storage needs no reset; stale slots are masked by count
  always_ff @(posedge clk) begin
    if (we && !clr) mem[wr_ptr_q] <= {wa, wd};
  end
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/mips32_run_monitor.sv
// mips32_run_monitor: core run gating, halt/timeout completion and store trace (trace built only with RUN_MON_TRACE_EN)
module mips32_run_monitor
  import mips32_sim_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CYC_W        = 32,
  parameter int MAX_CYCLES   = 2000,
  parameter int HALT_REPEAT  = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic [ADDR_W-1:0]              Next_PC_IF,
  input  logic                           MemWrite_MEM,
  input  logic [ADDR_W-1:0]              Mem_Addr_MEM,
  input  logic [DATA_W-1:0]              Write_Data_MUX_MEM,
  output logic                           Core_Run,
  output logic                           Done,
  output logic [1:0]                     Done_Cause,
  output logic [CYC_W-1:0]               Cycle_Count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] Trace_Rd_Idx,
  output logic [ADDR_W-1:0]              Trace_Rd_Addr,
  output logic [DATA_W-1:0]              Trace_Rd_Data,
  output logic [$clog2(TRACE_DEPTH):0]   Trace_Count,
  output logic                           Trace_Overflow
);
  localparam int HW = $clog2(HALT_REPEAT + 1);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  run_state_t state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [HW-1:0] halt_q, halt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [ADDR_W-1:0] pc_q;
  logic core_run_q, core_run_d, done_q, done_d, clr;
  // next state, counters and run clear; halt is checked before timeout so it wins a tie
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cycle_d = cycle_q;
    halt_d  = halt_q;
    drain_d = drain_q;
    clr     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (Start) begin
        state_d = S_RUN;
        cause_d = DONE_NONE;
        cycle_d = '0;
        halt_d  = '0;
        clr     = 1'b1;
      end
      S_RUN: begin
        cycle_d = cycle_q + CYC_W'(1);
        halt_d  = (Next_PC_IF != pc_q) ? '0 : (halt_q == HW'(HALT_REPEAT)) ? halt_q : halt_q + HW'(1);
        if (halt_d == HW'(HALT_REPEAT)) begin
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          cause_d = (DRAIN_CYCLES == 0) ? DONE_HALT : cause_q;
          drain_d = '0;
        end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
          state_d = S_DONE;
          cause_d = DONE_TIMEOUT;
        end
      end
      S_DRAIN: begin
        cycle_d = cycle_q + CYC_W'(1);
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          cause_d = DONE_HALT;
        end
      end
    endcase
    core_run_d = state_d == S_RUN || state_d == S_DRAIN;
    done_d     = state_d == S_DONE;
  end
  // state and registered outputs; the previous PC is tracked every cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cause_q    <= DONE_NONE;
      cycle_q    <= '0;
      halt_q     <= '0;
      drain_q    <= '0;
      pc_q       <= '0;
      core_run_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cycle_q    <= cycle_d;
      halt_q     <= halt_d;
      drain_q    <= drain_d;
      pc_q       <= Next_PC_IF;
      core_run_q <= core_run_d;
      done_q     <= done_d;
    end
  end
  assign Core_Run    = core_run_q;
  assign Done        = done_q;
  assign Done_Cause  = cause_q;
  assign Cycle_Count = cycle_q;
`ifdef RUN_MON_TRACE_EN
  mips32_trace_buf #(
    .TRACE_DEPTH(TRACE_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_trace (
    .clk(Clk),
    .rst(Reset),
    .clr(clr),
    .we(core_run_q && MemWrite_MEM),
    .wa(Mem_Addr_MEM),
    .wd(Write_Data_MUX_MEM),
    .rd_idx(Trace_Rd_Idx),
    .rd_addr(Trace_Rd_Addr),
    .rd_data(Trace_Rd_Data),
    .count(Trace_Count),
    .overflow(Trace_Overflow)
  );
`else
  logic unused_trace;
  assign unused_trace   = ^{clr, MemWrite_MEM, Mem_Addr_MEM, Write_Data_MUX_MEM, Trace_Rd_Idx};
  assign Trace_Rd_Addr  = '0;
  assign Trace_Rd_Data  = '0;
  assign Trace_Count    = '0;
  assign Trace_Overflow = 1'b0;
`endif
endmodule

// File: tb/tb_mips32_run_monitor.sv
// tb_mips32_run_monitor: randomized checks of run control, completion and trace against a queue-based model
module tb_mips32_run_monitor;
`ifdef RUN_MON_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif
  localparam int MAXC = 50;
  localparam int HREP = 4;
  localparam int DRN  = 4;
  localparam int DEP  = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mw = 1'b0;
  logic [31:0] pc = '0, maddr = '0, mdata = '0;
  logic [3:0] rd_idx = '0;
  logic core_run, done, tovf;
  logic [1:0] cause;
  logic [31:0] cyc, rd_addr, rd_data;
  logic [4:0] tcount;
  logic [41:0] act_st;
  logic [63:0] act_rd;
  int vectors = 0, miscompares = 0;
  int m_st, m_cyc, m_rep, m_drain_left, m_cause;
  logic [31:0] m_prev_pc;
  logic m_ovf;
  logic [63:0] m_tr[$];
  logic [63:0] m_rd;

  mips32_run_monitor #(
    .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP), .DRAIN_CYCLES(DRN), .TRACE_DEPTH(DEP)
  ) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Next_PC_IF(pc),
    .MemWrite_MEM(mw), .Mem_Addr_MEM(maddr), .Write_Data_MUX_MEM(mdata),
    .Core_Run(core_run), .Done(done), .Done_Cause(cause), .Cycle_Count(cyc),
    .Trace_Rd_Idx(rd_idx), .Trace_Rd_Addr(rd_addr), .Trace_Rd_Data(rd_data),
    .Trace_Count(tcount), .Trace_Overflow(tovf)
  );

  always #5 clk = ~clk;
  assign act_st = {core_run, done, cause, cyc, tcount, tovf};
  assign act_rd = {rd_addr, rd_data};

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_rep = 0; m_drain_left = 0; m_cause = 0;
    m_prev_pc = '0; m_ovf = 1'b0; m_tr.delete(); m_rd = '0;
  endtask

  // state: 0 idle, 1 run, 2 drain, 3 done
  task automatic model_step();
    bit running;
    running = (m_st == 1 || m_st == 2);
    m_rd = (TRACE_EN && int'(rd_idx) < m_tr.size()) ? m_tr[rd_idx] : 64'd0;
    if (running && mw) begin
      if (m_tr.size() == DEP) begin
        void'(m_tr.pop_front());
        m_ovf = 1'b1;
      end
      m_tr.push_back({maddr, mdata});
    end
    if ((m_st == 0 || m_st == 3) && start) begin
      m_st = 1; m_cyc = 0; m_rep = 0; m_tr.delete(); m_ovf = 1'b0; m_cause = 0;
    end else if (m_st == 1) begin
      m_cyc++;
      m_rep = (pc == m_prev_pc) ? ((m_rep < HREP) ? m_rep + 1 : HREP) : 0;
      if (m_rep >= HREP) begin
        m_st = 2; m_drain_left = DRN;
      end else if (m_cyc == MAXC) begin
        m_st = 3; m_cause = 2;
      end
    end else if (m_st == 2) begin
      m_cyc++;
      m_drain_left--;
      if (m_drain_left == 0) begin
        m_st = 3; m_cause = 1;
      end
    end
    m_prev_pc = pc;
  endtask

  function automatic logic [41:0] exp_status();
    logic [4:0] tc;
    tc = TRACE_EN ? 5'(m_tr.size()) : 5'd0;
    return {m_st == 1 || m_st == 2, m_st == 3, 2'(m_cause), 32'(m_cyc), tc, TRACE_EN ? m_ovf : 1'b0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_store();
    mw = 1'($urandom_range(0, 1));
    maddr = $urandom;
    mdata = $urandom;
    rd_idx = 4'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++; if (act_st !== 42'd0) begin miscompares++; $display("FAIL reset_status act=%h exp=0", act_st); end
    vectors++; if (act_rd !== 64'd0) begin miscompares++; $display("FAIL reset_read act=%h exp=0", act_rd); end
    rst = 1'b0;
    rd_idx = 4'd3;
    pc = 32'h40;
    tick();
    vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL idle_status act=%h exp=%h", act_st, exp_status()); end
  endtask

  task automatic test_halt();
    pc = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (core_run !== 1'b1 || cyc !== 32'd0) begin miscompares++; $display("FAIL halt_start core_run=%b cyc=%0d exp 1/0", core_run, cyc); end
    for (int i = 0; i < 30 && m_st != 3; i++) begin
      pc = (i < 4) ? 32'(4 * i) : 32'd12;
      rand_store();
      tick();
      vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL halt_status i=%0d act=%h exp=%h", i, act_st, exp_status()); end
      vectors++; if (act_rd !== m_rd) begin miscompares++; $display("FAIL halt_read i=%0d act=%h exp=%h", i, act_rd, m_rd); end
    end
    mw = 1'b0;
    vectors++; if (done !== 1'b1 || cause !== 2'b01 || cyc !== 32'd12) begin miscompares++; $display("FAIL halt_final done=%b cause=%b cyc=%0d exp 1/01/12", done, cause, cyc); end
  endtask

  task automatic test_timeout();
    pc = 32'hFFFF_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 70 && m_st != 3; k++) begin
      pc = 32'(4 * k);
      rand_store();
      tick();
      vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL timeout_status k=%0d act=%h exp=%h", k, act_st, exp_status()); end
      vectors++; if (act_rd !== m_rd) begin miscompares++; $display("FAIL timeout_read k=%0d act=%h exp=%h", k, act_rd, m_rd); end
    end
    mw = 1'b0;
    vectors++; if (done !== 1'b1 || cause !== 2'b10 || cyc !== 32'd50 || core_run !== 1'b0) begin miscompares++; $display("FAIL timeout_final done=%b cause=%b cyc=%0d exp 1/10/50", done, cause, cyc); end
  endtask

  task automatic test_simultaneous();
    pc = 32'hFFFF_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 70 && m_st != 3; k++) begin
      pc = (k <= 46) ? 32'(4 * k) : 32'd184;
      rand_store();
      tick();
      vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL simul_status k=%0d act=%h exp=%h", k, act_st, exp_status()); end
    end
    mw = 1'b0;
    vectors++; if (done !== 1'b1 || cause !== 2'b01 || cyc !== 32'd54) begin miscompares++; $display("FAIL simul_final done=%b cause=%b cyc=%0d exp 1/01/54", done, cause, cyc); end
  endtask

  task automatic test_wrap_restart();
    pc = 32'h7000; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (done !== 1'b0 || core_run !== 1'b1 || cyc !== 32'd0 || tcount !== 5'd0 || tovf !== 1'b0) begin miscompares++; $display("FAIL restart_clear done=%b run=%b cyc=%0d tc=%0d ovf=%b exp 0/1/0/0/0", done, core_run, cyc, tcount, tovf); end
    for (int i = 0; i < 20; i++) begin
      pc = 32'(1000 + 4 * i);
      mw = 1'b1; maddr = 32'(4 * i); mdata = 32'(i); rd_idx = 4'($urandom);
      tick();
      vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL wrap_status i=%0d act=%h exp=%h", i, act_st, exp_status()); end
    end
    mw = 1'b0;
    vectors++; if (tcount !== (TRACE_EN ? 5'd16 : 5'd0) || tovf !== TRACE_EN) begin miscompares++; $display("FAIL wrap_count tc=%0d ovf=%b exp %0d/%b", tcount, tovf, TRACE_EN ? 16 : 0, TRACE_EN); end
    rd_idx = 4'd0; pc = 32'd2000;
    tick();
    vectors++; if (act_rd !== (TRACE_EN ? {32'd16, 32'd4} : 64'd0)) begin miscompares++; $display("FAIL wrap_idx0 act=%h exp=%h", act_rd, TRACE_EN ? {32'd16, 32'd4} : 64'd0); end
    rd_idx = 4'd15; pc = 32'd2004;
    tick();
    vectors++; if (act_rd !== (TRACE_EN ? {32'd76, 32'd19} : 64'd0)) begin miscompares++; $display("FAIL wrap_idx15 act=%h exp=%h", act_rd, TRACE_EN ? {32'd76, 32'd19} : 64'd0); end
    for (int k = 0; k < 60 && m_st != 3; k++) begin
      pc = 32'(3000 + 4 * k);
      rd_idx = 4'($urandom);
      tick();
      vectors++; if (act_rd !== m_rd) begin miscompares++; $display("FAIL wrap_read k=%0d act=%h exp=%h", k, act_rd, m_rd); end
    end
    vectors++; if (act_st !== exp_status() || done !== 1'b1) begin miscompares++; $display("FAIL wrap_end act=%h exp=%h", act_st, exp_status()); end
  endtask

  task automatic test_reset_mid();
    pc = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(32'h20 + 4 * i); mw = 1'b1; maddr = $urandom; mdata = $urandom;
      tick();
    end
    mw = 1'b0;
    vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL midrst_pre act=%h exp=%h", act_st, exp_status()); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (core_run !== 1'b0 || act_st !== 42'd0 || act_rd !== 64'd0) begin miscompares++; $display("FAIL midrst_async st=%h rd=%h exp 0", act_st, act_rd); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pc = 32'h500; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (tcount !== 5'd0 || core_run !== 1'b1 || act_st !== exp_status()) begin miscompares++; $display("FAIL midrst_restart tc=%0d run=%b st=%h exp %h", tcount, core_run, act_st, exp_status()); end
    for (int k = 0; k < 80 && m_st != 3; k++) begin
      pc = 32'(32'h600 + 4 * k);
      rand_store();
      tick();
      vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL midrst_status k=%0d act=%h exp=%h", k, act_st, exp_status()); end
    end
    mw = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      pc = $urandom; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 80 && m_st != 3; k++) begin
        if ($urandom_range(0, 2) != 0) pc = $urandom;
        start = ($urandom_range(0, 7) == 0);
        rand_store();
        tick();
        vectors++; if (act_st !== exp_status()) begin miscompares++; $display("FAIL rand_status r=%0d k=%0d act=%h exp=%h", r, k, act_st, exp_status()); end
        vectors++; if (act_rd !== m_rd) begin miscompares++; $display("FAIL rand_read r=%0d k=%0d act=%h exp=%h", r, k, act_rd, m_rd); end
      end
      start = 1'b0; mw = 1'b0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rand_budget r=%0d done=%b exp 1", r, done); end
      for (int k = 0; k < 3; k++) begin
        rd_idx = 4'($urandom);
        tick();
        vectors++; if (act_rd !== m_rd || act_st !== exp_status()) begin miscompares++; $display("FAIL rand_doneread r=%0d rd=%h exp=%h", r, act_rd, m_rd); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_halt();
    test_timeout();
    test_simultaneous();
    test_wrap_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
